// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
//   Opcodes (6-bit, zero-extended when OPCODE_LENGTH is wider):
//   20h ADD, 22h SUB, 24h AND, 25h OR, 26h XOR, 27h NOR, 02h SRL, 03h SRA, 18h MUL.
//   Compile-time option ALU_MUL_EN: when defined, 18h is an iterative signed multiply
//   (DATA_LENGTH steps, latency DATA_LENGTH+1). When undefined, 18h is unsupported.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_valid / o_ready   input handshake; i_a, i_b, i_op are captured on accept
//   o_valid / i_ready   output handshake; result and flags are held while i_ready=0
//   o_result            result
//   o_zero, o_neg       result == 0, result MSB
//   o_carry, o_ovf      ADD carry / SUB borrow, signed overflow (ADD/SUB/MUL)
//   o_err               unsupported opcode
module alu_seq #(
    parameter int unsigned DATA_LENGTH   = 8,
    parameter int unsigned OPCODE_LENGTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_LENGTH-1:0]   i_a,
    input  logic [DATA_LENGTH-1:0]   i_b,
    input  logic [OPCODE_LENGTH-1:0] i_op,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_LENGTH-1:0]   o_result,
    output logic                     o_zero,
    output logic                     o_neg,
    output logic                     o_carry,
    output logic                     o_ovf,
    output logic                     o_err
);

    localparam int unsigned N = DATA_LENGTH;

    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(6'h20);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(6'h22);
    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(6'h24);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(6'h25);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(6'h26);
    localparam logic [OPCODE_LENGTH-1:0] OP_NOR = OPCODE_LENGTH'(6'h27);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(6'h02);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(6'h03);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OUT
`ifdef ALU_MUL_EN
        , S_MUL
`endif
    } state_t;

    state_t         state_q;
    logic           valid_q;
    logic [N-1:0]   result_q;
    logic           zero_q, neg_q, carry_q, ovf_q, err_q;

    logic           accept;
    logic [N:0]     sum_w, diff_w;
    logic           shift_big;
    logic [N-1:0]   res_d;
    logic           carry_d, ovf_d, err_d;

    assign o_ready  = (state_q == S_IDLE) || ((state_q == S_OUT) && i_ready);
    assign accept   = i_valid && o_ready;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_zero   = zero_q;
    assign o_neg    = neg_q;
    assign o_carry  = carry_q;
    assign o_ovf    = ovf_q;
    assign o_err    = err_q;

    // Single-cycle datapath evaluated on the live inputs; only used on accept.
    always_comb begin
        res_d     = '0;
        carry_d   = 1'b0;
        ovf_d     = 1'b0;
        err_d     = 1'b0;
        sum_w     = {1'b0, i_a} + {1'b0, i_b};
        diff_w    = {1'b0, i_a} - {1'b0, i_b};
        shift_big = (i_b >= DATA_LENGTH'(DATA_LENGTH));
        case (i_op)
            OP_ADD: begin
                res_d   = sum_w[N-1:0];
                carry_d = sum_w[N];
                ovf_d   = (i_a[N-1] == i_b[N-1]) && (sum_w[N-1] != i_a[N-1]);
            end
            OP_SUB: begin
                res_d   = diff_w[N-1:0];
                carry_d = diff_w[N];
                ovf_d   = (i_a[N-1] != i_b[N-1]) && (diff_w[N-1] != i_a[N-1]);
            end
            OP_AND: res_d = i_a & i_b;
            OP_OR:  res_d = i_a | i_b;
            OP_XOR: res_d = i_a ^ i_b;
            OP_NOR: res_d = ~(i_a | i_b);
            OP_SRL: res_d = shift_big ? '0 : (i_a >> i_b);
            OP_SRA: res_d = shift_big ? {N{i_a[N-1]}} : N'($signed(i_a) >>> i_b);
            default: err_d = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int unsigned CNT_W = $clog2(DATA_LENGTH);
    localparam logic [OPCODE_LENGTH-1:0] OP_MUL = OPCODE_LENGTH'(6'h18);

    logic [2*N-1:0] mcand_q, prod_q, mul_acc;
    logic [N-1:0]   mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic           is_mul, mul_last, mul_ovf;

    assign is_mul   = (i_op == OP_MUL);
    assign mul_last = (cnt_q == CNT_W'(N-1));

    // Shift-add over the bits of B; the sign bit of B carries negative weight,
    // so the final step subtracts the shifted multiplicand.
    always_comb begin
        mul_acc = prod_q;
        if (mplier_q[0]) begin
            mul_acc = mul_last ? (prod_q - mcand_q) : (prod_q + mcand_q);
        end
        mul_ovf = (mul_acc[2*N-1:N] != {N{mul_acc[N-1]}});
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else if (accept) begin
`ifdef ALU_MUL_EN
            if (is_mul) begin
                state_q  <= S_MUL;
                valid_q  <= 1'b0;
                mcand_q  <= {{N{i_a[N-1]}}, i_a};
                mplier_q <= i_b;
                prod_q   <= '0;
                cnt_q    <= '0;
            end else
`endif
            begin
                state_q  <= S_OUT;
                valid_q  <= 1'b1;
                result_q <= res_d;
                zero_q   <= (res_d == '0);
                neg_q    <= res_d[N-1];
                carry_q  <= carry_d;
                ovf_q    <= ovf_d;
                err_q    <= err_d;
            end
        end else begin
            case (state_q)
                S_OUT: begin
                    if (i_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    prod_q   <= mul_acc;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (mul_last) begin
                        state_q  <= S_OUT;
                        valid_q  <= 1'b1;
                        result_q <= mul_acc[N-1:0];
                        zero_q   <= (mul_acc[N-1:0] == '0);
                        neg_q    <= mul_acc[N-1];
                        carry_q  <= 1'b0;
                        ovf_q    <= mul_ovf;
                        err_q    <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table, back-pressure / reset sequences and randomized
// traffic for alu_seq (DATA_LENGTH=8), checked against an arithmetic model.
module tb_alu_seq;

    localparam int unsigned N  = 8;
    localparam int unsigned OL = 6;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid, o_ready, o_valid, i_ready;
    logic [N-1:0]  i_a, i_b, o_result;
    logic [OL-1:0] i_op;
    logic          o_zero, o_neg, o_carry, o_ovf, o_err;

    always #5 clk = ~clk;

    alu_seq #(.DATA_LENGTH(N), .OPCODE_LENGTH(OL)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_op(i_op),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_zero(o_zero), .o_neg(o_neg),
        .o_carry(o_carry), .o_ovf(o_ovf), .o_err(o_err)
    );

    typedef struct packed {
        logic [7:0] res;
        logic       zero, neg, carry, ovf, err;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] a, b;
        logic [5:0] op;
        exp_t       e;
    } vec_t;

    int passed = 0;
    int total  = 0;
    vec_t vecs[17];

    function automatic exp_t mk(logic [7:0] r, logic z, logic n, logic c, logic o, logic e);
        exp_t x;
        x.res = r; x.zero = z; x.neg = n; x.carry = c; x.ovf = o; x.err = e;
        return x;
    endfunction

    // Reference model straight from the opcode rules, using integer arithmetic.
    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic [5:0] op);
        exp_t e;
        int sa, sb, s;
        e  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            6'h20: begin
                s = int'(a) + int'(b); e.res = 8'(s); e.carry = (s > 255);
                s = sa + sb; e.ovf = (s > 127) || (s < -128);
            end
            6'h22: begin
                s = int'(a) - int'(b); e.res = 8'(s); e.carry = (s < 0);
                s = sa - sb; e.ovf = (s > 127) || (s < -128);
            end
            6'h24: e.res = a & b;
            6'h25: e.res = a | b;
            6'h26: e.res = a ^ b;
            6'h27: e.res = ~(a | b);
            6'h02: begin s = int'(a); repeat (int'(b)) s = s / 2; e.res = 8'(s); end
            6'h03: begin s = sa; repeat (int'(b)) s = s >>> 1; e.res = 8'(s); end
            6'h18: begin
                if (MUL_EN) begin
                    s = sa * sb; e.res = 8'(s); e.ovf = (s > 127) || (s < -128);
                end else begin
                    e.err = 1'b1;
                end
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 8'h00);
        e.neg  = e.res[7];
        return e;
    endfunction

    function automatic int exp_lat(logic [5:0] op);
        return (op == 6'h18 && MUL_EN) ? int'(N) + 1 : 1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, req);
    endtask

    function automatic exp_t dut_out();
        return mk(o_result, o_zero, o_neg, o_carry, o_ovf, o_err);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one op from IDLE with i_ready=1, then check latency, result and return to IDLE.
    task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] op, input exp_t e);
        int lat;
        i_a = a; i_b = b; i_op = op; i_valid = 1'b1; i_ready = 1'b1;
        #1;
        check({nm, " ready"}, 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        i_a = 8'($urandom); i_b = 8'($urandom); i_op = 6'($urandom);
        lat = 1;
        while (!o_valid && lat < 40) begin
            check({nm, " busy"}, 32'(o_ready), 32'd0);
            tick();
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(exp_lat(op)));
        check({nm, " out"}, 32'(dut_out()), 32'(e));
        tick();
        check({nm, " idle"}, 32'(o_valid), 32'd0);
    endtask

    task automatic gen_single(output logic [7:0] a, output logic [7:0] b, output logic [5:0] op);
        logic [5:0] ops [9];
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03, 6'h00};
        a  = 8'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
        op = ops[$urandom_range(0, 8)];
        if (op == 6'h00) begin
            op = 6'($urandom);
            if (op == 6'h18) op = 6'h3F;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: %0d/%0d", passed, total);
        $fatal(1);
    end

    initial begin
        exp_t e1, e2, ex;
        exp_t q[$];
        logic [7:0] a, b;
        logic [5:0] op;
        bit seen;

        vecs[0]  = '{"add_ovf",   8'h64, 8'h32, 6'h20, mk(8'h96, 0, 1, 0, 1, 0)};
        vecs[1]  = '{"sub_borrow",8'h05, 8'h07, 6'h22, mk(8'hFE, 0, 1, 1, 0, 0)};
        vecs[2]  = '{"sra3",      8'h80, 8'h03, 6'h03, mk(8'hF0, 0, 1, 0, 0, 0)};
        vecs[3]  = '{"srl9",      8'h80, 8'h09, 6'h02, mk(8'h00, 1, 0, 0, 0, 0)};
        vecs[4]  = '{"sra9",      8'h80, 8'h09, 6'h03, mk(8'hFF, 0, 1, 0, 0, 0)};
        vecs[5]  = '{"bad_op",    8'h12, 8'h34, 6'h3F, mk(8'h00, 1, 0, 0, 0, 1)};
        vecs[6]  = '{"add_carry", 8'hFF, 8'h01, 6'h20, mk(8'h00, 1, 0, 1, 0, 0)};
        vecs[7]  = '{"sub_ovf",   8'h80, 8'h01, 6'h22, mk(8'h7F, 0, 0, 0, 1, 0)};
        vecs[8]  = '{"and",       8'hF0, 8'h3C, 6'h24, mk(8'h30, 0, 0, 0, 0, 0)};
        vecs[9]  = '{"or",        8'hF0, 8'h0F, 6'h25, mk(8'hFF, 0, 1, 0, 0, 0)};
        vecs[10] = '{"xor",       8'hAA, 8'hAA, 6'h26, mk(8'h00, 1, 0, 0, 0, 0)};
        vecs[11] = '{"nor",       8'h0F, 8'h30, 6'h27, mk(8'hC0, 0, 1, 0, 0, 0)};
        vecs[12] = '{"srl7",      8'h80, 8'h07, 6'h02, mk(8'h01, 0, 0, 0, 0, 0)};
        vecs[13] = '{"sra8_pos",  8'h7F, 8'h08, 6'h03, mk(8'h00, 1, 0, 0, 0, 0)};
        vecs[14] = '{"add_povf",  8'h7F, 8'h01, 6'h20, mk(8'h80, 0, 1, 0, 1, 0)};
`ifdef ALU_MUL_EN
        vecs[15] = '{"mul_neg",   8'hFD, 8'h05, 6'h18, mk(8'hF1, 0, 1, 0, 0, 0)};
        vecs[16] = '{"mul_ovf",   8'h10, 8'h10, 6'h18, mk(8'h00, 1, 0, 0, 1, 0)};
`else
        vecs[15] = '{"mul_off",   8'hFD, 8'h05, 6'h18, mk(8'h00, 1, 0, 0, 0, 1)};
        vecs[16] = '{"mul_off2",  8'h10, 8'h10, 6'h18, mk(8'h00, 1, 0, 0, 0, 1)};
`endif

        reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_a = '0; i_b = '0; i_op = '0;
        tick(); tick();
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset ready", 32'(o_ready), 32'd1);
        check("reset outs",  32'(dut_out()), 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e);

        // Back-pressure: hold the first result for 5 cycles with a second op waiting.
        e1 = model(8'h64, 8'h32, 6'h20);
        e2 = model(8'h05, 8'h07, 6'h22);
        i_a = 8'h64; i_b = 8'h32; i_op = 6'h20; i_valid = 1'b1; i_ready = 1'b0;
        tick();
        i_a = 8'h05; i_b = 8'h07; i_op = 6'h22;
        for (int i = 0; i < 5; i++) begin
            check("bp valid", 32'(o_valid), 32'd1);
            check("bp ready", 32'(o_ready), 32'd0);
            check("bp hold",  32'(dut_out()), 32'(e1));
            tick();
        end
        i_ready = 1'b1;
        #1;
        check("bp release ready", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        check("bp next valid", 32'(o_valid), 32'd1);
        check("bp next out",   32'(dut_out()), 32'(e2));
        tick();
        check("bp idle", 32'(o_valid), 32'd0);

        // Back-to-back single-cycle stream at one op per cycle.
        i_ready = 1'b1;
        gen_single(a, b, op);
        i_a = a; i_b = b; i_op = op; i_valid = 1'b1;
        q.push_back(model(a, b, op));
        for (int k = 0; k < 40; k++) begin
            tick();
            ex = q.pop_front();
            check("b2b valid", 32'(o_valid), 32'd1);
            check("b2b out",   32'(dut_out()), 32'(ex));
            if (k < 39) begin
                gen_single(a, b, op);
                i_a = a; i_b = b; i_op = op;
                q.push_back(model(a, b, op));
            end else begin
                i_valid = 1'b0;
            end
        end
        tick();
        check("b2b idle", 32'(o_valid), 32'd0);

        // Randomized single ops, including multiplies and unsupported opcodes.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                a = 8'($urandom); b = 8'($urandom); op = 6'h18;
            end else begin
                gen_single(a, b, op);
            end
            do_op("rand", a, b, op, model(a, b, op));
        end

        // Reset while an op is in flight discards it.
`ifdef ALU_MUL_EN
        i_a = 8'hFD; i_b = 8'h05; i_op = 6'h18; i_valid = 1'b1; i_ready = 1'b1;
`else
        i_a = 8'h64; i_b = 8'h32; i_op = 6'h20; i_valid = 1'b1; i_ready = 1'b0;
`endif
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("midop reset valid", 32'(o_valid), 32'd0);
        check("midop reset ready", 32'(o_ready), 32'd1);
        reset = 1'b0;
        i_ready = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (o_valid) seen = 1'b1;
        end
        check("midop discarded", 32'(seen), 32'd0);
        do_op("after_reset", 8'h03, 8'h04, 6'h20, model(8'h03, 8'h04, 6'h20));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
